// File: rtl/mux2_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter_if
// Bundles the two requester channels, the grant/select outputs and the
// downstream valid/ready handshake of the two-way round-robin arbiter.
//
// Signals:
//   req0/req1   requester requests (held high while data is pending)
//   d0/d1       requester data, WIDTH bits
//   lock0/lock1 burst-lock requests (only when MUX2_ARB_LOCK_EN is defined)
//   gnt0/gnt1   one-hot grants (or both low)
//   s           datapath mux select (0 = d0, 1 = d1)
//   out_data    selected data, out_valid / out_ready downstream handshake
//
// Modports:
//   master  requester/downstream side (drives requests, data and ready)
//   slave   arbiter side
//
// Optional feature macro: MUX2_ARB_LOCK_EN
// ---------------------------------------------------------------------------
interface mux2_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
`ifdef MUX2_ARB_LOCK_EN
    logic             lock0;
    logic             lock1;
`endif
    logic             gnt0;
    logic             gnt1;
    logic             s;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output req0, req1, d0, d1, out_ready,
`ifdef MUX2_ARB_LOCK_EN
        output lock0, lock1,
`endif
        input  gnt0, gnt1, s, out_data, out_valid
    );

    modport slave (
        input  req0, req1, d0, d1, out_ready,
`ifdef MUX2_ARB_LOCK_EN
        input  lock0, lock1,
`endif
        output gnt0, gnt1, s, out_data, out_valid
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter
// Two-requester round-robin arbiter driving a 2:1 data mux. A grant lasts
// until the holder drops its request or MAX_BURST beats have been accepted;
// the next grant is then handed over on the same edge (no idle cycle).
// Under contention the requester that was not granted last wins.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux2_rr_arbiter_if.slave (requests, data, grants, select,
//          out_data/out_valid/out_ready handshake)
//
// Parameters:
//   WIDTH      data width (default 8)
//   MAX_BURST  beats per grant, 1..255 (default 4)
//
// Optional feature macro: MUX2_ARB_LOCK_EN -- adds lock0/lock1; while the
// granted requester holds its lock the burst limit is ignored and only a
// dropped request ends the grant.
// ---------------------------------------------------------------------------
module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux2_rr_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    // Round-robin pick: a lone requester wins; with both requesting, the one
    // that is not `last` wins.
    function automatic logic pick_winner(input logic r0, input logic r1,
                                         input logic last);
        logic w;
        if (r0 && r1) begin
            w = ~last;
        end else begin
            w = r1;
        end
        return w;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             last_r;
    logic             s_r;
    logic [7:0]       cnt_r;
    logic             winner_s;
    logic             any_req_s;
    logic             accept_s;
    logic             valid_s;
    logic             release_s;
    logic             grant_s;
    logic             lock_s;
    logic [WIDTH-1:0] out_data_s;

    // Lock qualifier for the current grant holder.
    always_comb begin
`ifdef MUX2_ARB_LOCK_EN
        lock_s = ((state_r == G0) && bus.lock0) || ((state_r == G1) && bus.lock1);
`else
        lock_s = 1'b0;
`endif
    end

    // Handshake and datapath: valid follows the holder's request, data is a
    // pure mux on the registered select.
    always_comb begin
        valid_s  = ((state_r == G0) && bus.req0) || ((state_r == G1) && bus.req1);
        accept_s = valid_s && bus.out_ready;
        if (s_r) begin
            out_data_s = bus.d1;
        end else begin
            out_data_s = bus.d0;
        end
    end

    // Next-state logic: release decision, then hand-over to the winner.
    always_comb begin
        state_nxt_s = state_r;
        release_s   = 1'b0;
        grant_s     = 1'b0;
        any_req_s   = bus.req0 || bus.req1;
        winner_s    = pick_winner(bus.req0, bus.req1, last_r);
        case (state_r)
            IDLE: begin
                release_s = 1'b1;
            end
            G0: begin
                if (!bus.req0 || (accept_s && (cnt_r == LAST_BEAT) && !lock_s)) begin
                    release_s = 1'b1;
                end else begin
                    release_s = 1'b0;
                end
            end
            G1: begin
                if (!bus.req1 || (accept_s && (cnt_r == LAST_BEAT) && !lock_s)) begin
                    release_s = 1'b1;
                end else begin
                    release_s = 1'b0;
                end
            end
            default: begin
                release_s = 1'b1;
            end
        endcase
        // IDLE counts as "released": it grants as soon as anyone asks.
        if (release_s && any_req_s) begin
            grant_s     = 1'b1;
            state_nxt_s = winner_s ? G1 : G0;
        end else if (release_s) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, round-robin history, select and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            s_r     <= 1'b0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                cnt_r  <= 8'd0;
                last_r <= winner_s;
                s_r    <= winner_s;
            end else if (accept_s) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.gnt0      = (state_r == G0);
    assign bus.gnt1      = (state_r == G1);
    assign bus.s         = s_r;
    assign bus.out_valid = valid_s;
    assign bus.out_data  = out_data_s;

endmodule

// File: doc/mux2_rr_arbiter.md
MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of both requester channels and the output.
REQ-002 Parameter MAX_BURST, default 4: maximum beats per grant; legal range 1..255.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0 / req1  input  1 each  request from requester 0 / 1; held high while data is pending.
REQ-006 d0 / d1  input  WIDTH each  requester data; stable while req is high and the beat is not yet accepted.
REQ-007 gnt0 / gnt1  output  1 each  grant; one-hot or both low.
REQ-008 s  output  1  mux select driven to the datapath (0 = d0, 1 = d1).
REQ-009 out_data  output  WIDTH  selected data: d0 when s=0, d1 when s=1.
REQ-010 out_valid  output  1  a beat from the granted requester is present.
REQ-011 out_ready  input  1  downstream accepts a beat when out_valid and out_ready are both high.

Function
REQ-012 The state machine SHALL have exactly three states: IDLE, G0 (requester 0 granted) and G1 (requester 1 granted).
REQ-013 gnt0 SHALL be high only in G0; gnt1 SHALL be high only in G1; both SHALL be low in IDLE.
REQ-014 out_valid SHALL equal (G0 and req0) or (G1 and req1), combinationally.
REQ-015 out_data SHALL be a combinational function of s, d0 and d1, with no register stage.
REQ-016 s SHALL be 0 in G0 and 1 in G1; in IDLE it SHALL hold its last value.
REQ-017 A register "last" SHALL record the most recently granted requester.
REQ-018 Arbitration:
- single requester: that requester wins;
- both requesting: the requester not equal to "last" wins.
REQ-019 From IDLE, when any req is high, the FSM SHALL enter the winner's grant state on the next edge (one-cycle request-to-grant latency).
REQ-020 A beat counter (8 bits) SHALL:
- clear on entry to any grant state;
- increment on each accepted beat.
REQ-021 In Gx, the grant SHALL be released at an edge when either:
- reqx is low; or
- a beat is accepted and the counter equals MAX_BURST-1.
REQ-022 On release, the FSM SHALL enter the winner's grant state directly using the arbitration rule in REQ-018 with "last"=x, or IDLE if neither req is high.
- This gives back-to-back grants with no idle cycle.
- Re-granting the same requester is allowed when it is the only requester.
REQ-023 If out_ready is low, the grant SHALL be held indefinitely and the counter SHALL not advance.
REQ-024 If reqx drops without a beat being accepted, this SHALL release the grant with no error indication.
REQ-025 With MAX_BURST=1, every accepted beat SHALL release the grant, giving strict alternation under contention.

Reset
REQ-026 While rst_n is low:
- state = IDLE; gnt0 = gnt1 = 0; s = 0; last = 1 (requester 0 wins first contention); counter = 0; out_valid = 0.
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately (asynchronously); the first grant after reset follows REQ-019.

Configuration
REQ-028 Macro MUX2_ARB_LOCK_EN, when defined, SHALL add inputs lock0 and lock1 (1 bit each).
- While in Gx with lockx high, the MAX_BURST release condition SHALL be suppressed; only reqx low releases the grant.
REQ-029 When MUX2_ARB_LOCK_EN is undefined, lock0/lock1 SHALL not exist and bursts SHALL always be limited by MAX_BURST.

Verification
REQ-030 Reset then req0=1 only, d0=0xA5, out_ready=1:
- gnt0=1 one cycle later; s=0; out_data=0xA5;
- grant released after 4 beats, then re-granted to requester 0 with no gap.
REQ-031 req0=req1=1 from reset, out_ready=1, MAX_BURST=4: grants SHALL be G0 for 4 cycles, G1 for 4 cycles, G0 for 4 cycles, continuing in alternation.
REQ-032 In G1, out_ready=0 for 10 cycles, then 1: gnt1 held throughout; counter unchanged during the stall; 4 beats accepted after the stall.
REQ-033 In G0 after 2 beats, req0 drops with req1=1: G1 entered on the next edge; s=1; out_data=d1.
REQ-034 rst_n pulsed low mid-burst in G1: gnt1 falls immediately; after release, with both requesting, requester 0 is granted first.
REQ-035 With MUX2_ARB_LOCK_EN defined, lock0=1 and req0 held for 9 beats while req1=1: gnt0 held for all 9 beats; G1 follows on the edge after req0 falls.
